regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_writeback_wb_fifo.sv | 61 ++++++
 rtl/regfile_writeback.sv | 116 +++++++++++
 tb/tb_regfile_writeback.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-buffer entry type for the
// register-file writeback path.
package regfile_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int REG_NUMBER = 5;

    typedef struct packed {
        logic [REG_NUMBER-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order writeback buffer: storage, wrapping pointers and
// occupancy, with all slots exposed for the forwarding search.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [PW-1:0]         head_ptr,
    output logic [CW-1:0]         count
);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        unique case (1'b1)
            push && !pop: count_d = count_q + 1'b1;
            pop && !push: count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_entry;
    end

    assign head_entry = mem_q[head_q];
    assign entries    = mem_q;
    assign head_ptr   = head_q;
    assign count      = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU/memory producers into an in-order buffer
// that drains one entry per cycle, with operand forwarding.
module regfile_writeback #(
    parameter  int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter  int REG_NUMBER = regfile_pkg::REG_NUMBER,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_NUMBER-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_NUMBER-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_reg_write,
    output logic [REG_NUMBER-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data_rd,
    input  logic [REG_NUMBER-1:0] q_rs1,
    input  logic [REG_NUMBER-1:0] q_rs2,
    output logic                  fwd1_hit,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic                  fwd2_hit,
    output logic [DATA_WIDTH-1:0] fwd2_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);

    wb_entry_t             push_entry;
    wb_entry_t             head_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]         head_ptr;
    logic                  alu_fire;
    logic                  mem_fire;
    logic                  push;
    logic                  pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // ALU wins ties; nothing is accepted while reset is held.
    assign alu_ready = rst && !full;
    assign mem_ready = rst && !full && !alu_valid;
    assign alu_fire  = alu_valid && alu_ready;
    assign mem_fire  = mem_valid && mem_ready;

    always_comb begin
        push_entry = '0;
        push       = 1'b0;
        unique case (1'b1)
            alu_fire: begin
                push_entry.rd   = alu_rd;
                push_entry.data = alu_data;
                push            = (alu_rd != '0);
            end
            mem_fire: begin
                push_entry.rd   = mem_rd;
                push_entry.data = mem_data;
                push            = (mem_rd != '0);
            end
            default: ;
        endcase
    end

    assign pop = !empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head_entry(head_entry),
        .entries   (entries),
        .head_ptr  (head_ptr),
        .count     (count)
    );

    assign rf_reg_write = !empty;
    assign rf_rd        = empty ? '0 : head_entry.rd;
    assign rf_data_rd   = empty ? '0 : head_entry.data;

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (q_rs1 != '0 && entries[idx].rd == q_rs1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = entries[idx].data;
                end
                if (q_rs2 != '0 && entries[idx].rd == q_rs2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback with a scoreboard
// model of acceptance, occupancy and write order.
module tb_regfile_writeback;

    localparam int DW    = 20;
    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [RW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [RW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          rf_reg_write;
    logic [RW-1:0] rf_rd;
    logic [DW-1:0] rf_data_rd;
    logic [RW-1:0] q_rs1 = '0;
    logic [RW-1:0] q_rs2 = '0;
    logic          fwd1_hit;
    logic [DW-1:0] fwd1_data;
    logic          fwd2_hit;
    logic [DW-1:0] fwd2_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    regfile_writeback #(
        .DATA_WIDTH(DW),
        .REG_NUMBER(RW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .rf_reg_write(rf_reg_write),
        .rf_rd       (rf_rd),
        .rf_data_rd  (rf_data_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .fwd1_hit    (fwd1_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_hit    (fwd2_hit),
        .fwd2_data   (fwd2_data),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;

    int            n_checks = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;
    int            model_cnt = 0;
    exp_t          sb[$];
    logic [DW-1:0] rf_model [32];

    // Reference model: acceptance, rd==0 drop, one pop per cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_cnt <= 0;
            sb.delete();
        end else begin
            bit   p;
            int   nc;
            exp_t e;
            p  = 1'b0;
            nc = model_cnt;
            if (alu_valid && model_cnt != DEPTH) begin
                e.rd = alu_rd; e.data = alu_data; p = (alu_rd != 0);
            end else if (mem_valid && model_cnt != DEPTH) begin
                e.rd = mem_rd; e.data = mem_data; p = (mem_rd != 0);
            end
            if (p) sb.push_back(e);
            if (model_cnt != 0) nc = nc - 1;
            if (p) nc = nc + 1;
            model_cnt <= nc;
        end
    end

    always @(posedge clk) begin
        if (rst && rf_reg_write) rf_model[rf_rd] <= rf_data_rd;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            n_checks++;
            if (rf_reg_write !== (model_cnt != 0)) begin
                n_fail++;
                $display("FAIL mon_wr_en: got %b want %b", rf_reg_write, model_cnt != 0);
            end
            if (rf_reg_write === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_order: write x%0d=%0h with nothing expected", rf_rd, rf_data_rd);
                end else begin
                    e = sb.pop_front();
                    if ({rf_rd, rf_data_rd} !== {e.rd, e.data}) begin
                        n_fail++;
                        $display("FAIL mon_order: got x%0d=%0h want x%0d=%0h", rf_rd, rf_data_rd, e.rd, e.data);
                    end
                end
            end
            n_checks++;
            if (count !== CW'(model_cnt) || full !== (model_cnt == DEPTH) || empty !== (model_cnt == 0)) begin
                n_fail++;
                $display("FAIL mon_status: got cnt=%0d full=%b empty=%b want cnt=%0d", count, full, empty, model_cnt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        q_rs1 = 5'd5;
        q_rs2 = 5'd5;
        idle(2);
        n_checks++;
        if ({alu_ready, mem_ready, empty, full, rf_reg_write, fwd1_hit, fwd2_hit} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL reset_held: got %b want 0010000",
                     {alu_ready, mem_ready, empty, full, rf_reg_write, fwd1_hit, fwd2_hit});
        end
        @(posedge clk) #1;
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({empty, count, rf_reg_write, alu_ready, mem_ready} !== {1'b1, CW'(0), 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got e=%b c=%0d w=%b ar=%b mr=%b want 1 0 0 1 1",
                     empty, count, rf_reg_write, alu_ready, mem_ready);
        end
    endtask

    task automatic test_single();
        @(posedge clk) #1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 20'h11;
        @(negedge clk);
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", alu_ready);
        end
        @(posedge clk) #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rf_reg_write, rf_rd, rf_data_rd} !== {1'b1, 5'd3, 20'h11}) begin
            n_fail++;
            $display("FAIL single_write: got w=%b x%0d=%0h want 1 x3=11", rf_reg_write, rf_rd, rf_data_rd);
        end
        @(negedge clk);
        n_checks++;
        if (rf_model[3] !== 20'h11 || rf_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rf: got x3=%0h w=%b want 11 0", rf_model[3], rf_reg_write);
        end
    endtask

    task automatic test_priority();
        @(posedge clk) #1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 20'h2a;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 20'h3b;
        @(negedge clk);
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_ready: got %b want 10", {alu_ready, mem_ready});
        end
        @(posedge clk) #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_ready, rf_rd, rf_data_rd} !== {1'b1, 5'd2, 20'h2a}) begin
            n_fail++;
            $display("FAIL prio_first: got mr=%b x%0d=%0h want 1 x2=2a", mem_ready, rf_rd, rf_data_rd);
        end
        @(posedge clk) #1;
        mem_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rf_reg_write, rf_rd, rf_data_rd} !== {1'b1, 5'd4, 20'h3b}) begin
            n_fail++;
            $display("FAIL prio_second: got w=%b x%0d=%0h want 1 x4=3b", rf_reg_write, rf_rd, rf_data_rd);
        end
    endtask

    task automatic test_forward();
        q_rs1 = 5'd5;
        q_rs2 = 5'd0;
        @(posedge clk) #1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 20'h1;
        @(negedge clk);
        n_checks++;
        if (fwd1_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_early: got hit=%b want 0", fwd1_hit);
        end
        @(posedge clk) #1;
        alu_data = 20'h2;
        @(negedge clk);
        n_checks++;
        if ({fwd1_hit, fwd1_data} !== {1'b1, 20'h1}) begin
            n_fail++;
            $display("FAIL fwd_first: got %b/%0h want 1/1", fwd1_hit, fwd1_data);
        end
        @(posedge clk) #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== {1'b1, 20'h2, 1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL fwd_young: got %b/%0h %b/%0h want 1/2 0/0", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
        @(negedge clk);
        n_checks++;
        if ({fwd1_hit, fwd1_data} !== {1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL fwd_drain: got %b/%0h want 0/0", fwd1_hit, fwd1_data);
        end
    endtask

    task automatic test_back_to_back();
        int i = 0;
        int guard = 0;
        @(posedge clk) #1;
        while (i < DEPTH + 2 && guard < 50) begin
            alu_valid = 1'b1;
            alu_rd    = RW'(i + 1);
            alu_data  = DW'(32'h100 + i);
            @(negedge clk);
            n_checks++;
            if (alu_ready !== (model_cnt != DEPTH) || count > CW'(DEPTH)) begin
                n_fail++;
                $display("FAIL b2b_ready: got rdy=%b cnt=%0d want rdy=%b", alu_ready, count, model_cnt != DEPTH);
            end
            if (alu_ready === 1'b1) i++;
            guard++;
            @(posedge clk) #1;
        end
        alu_valid = 1'b0;
        n_checks++;
        if (i != DEPTH + 2) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d pushes want %0d", i, DEPTH + 2);
        end
        idle(DEPTH + 2);
        for (int k = 0; k < DEPTH + 2; k++) begin
            n_checks++;
            if (rf_model[k + 1] !== DW'(32'h100 + k)) begin
                n_fail++;
                $display("FAIL b2b_rf: got x%0d=%0h want %0h", k + 1, rf_model[k + 1], 32'h100 + k);
            end
        end
    endtask

    task automatic test_rd0();
        @(posedge clk) #1;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 20'h77;
        @(negedge clk);
        n_checks++;
        if ({alu_ready, count} !== {1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL rd0_ready: got rdy=%b cnt=%0d want 1 0", alu_ready, count);
        end
        @(posedge clk) #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({count, rf_reg_write, empty} !== {CW'(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rd0_drop: got cnt=%0d w=%b e=%b want 0 0 1", count, rf_reg_write, empty);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk) #1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 20'h55;
        @(posedge clk) #1;
        alu_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({count, rf_reg_write, empty, alu_ready, mem_ready} !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got cnt=%0d w=%b e=%b ar=%b mr=%b want 0 0 1 0 0",
                     count, rf_reg_write, empty, alu_ready, mem_ready);
        end
        @(posedge clk) #1;
        rst = 1'b1;
        idle(4);
        n_checks++;
        if (rf_model[7] !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_discard: got x7=%0h want 0", rf_model[7]);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
        test_reset();
        idle(2);
        test_single();
        idle(2);
        test_priority();
        idle(2);
        test_forward();
        idle(2);
        test_back_to_back();
        idle(2);
        test_rd0();
        idle(2);
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
